// File: rtl/handshake_tx_ctrl_pkg.sv
// Shared handshake-resync types: the four-phase sender state encoding.
// No latency or backpressure of its own; consumed by the sender control block.
// Only the state typedef is shared so both sides agree on the encoding.
package handshake_tx_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        REQ          = 2'd1,
        WAIT_ACK_LOW = 2'd2
    } tx_state_t;

endpackage

// File: rtl/handshake_tx_ctrl.sv
// Four-phase req/ack sender: captures one local word and holds it for the receiving domain.
// Latency: o_req rises the cycle after accept; next accept no sooner than 3 cycles + sync round trip.
// Backpressure: o_ready low whenever a transfer is in flight or a stale ack is still high.
module handshake_tx_ctrl
    import handshake_tx_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_req,
    input  logic                  i_ack,
    output logic                  o_busy,
    output logic                  o_timeout,
    input  logic                  i_timeout_clr
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    tx_state_t             state_q, state_d;
    logic                  req_q, req_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  timeout_q, timeout_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic                  accept;
    logic                  timeout_set;

    // A lingering ack from the previous transfer must drop before a new word is taken.
    assign o_ready = (state_q == IDLE) && !i_ack;
    assign accept  = i_valid && o_ready;

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        data_d      = data_q;
        timeout_d   = timeout_q;
        stall_cnt_d = stall_cnt_q;
        timeout_set = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    data_d  = i_data;
                end
            end
            REQ: begin
                if (i_ack) begin
                    state_d = WAIT_ACK_LOW;
                    req_d   = 1'b0;
                end
            end
            WAIT_ACK_LOW: begin
                if (!i_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        if ((state_d != state_q) || (state_d == IDLE)) begin
            stall_cnt_d = '0;
        end else if (stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        // Fire only on the step into the limit so a clear sticks while the counter sits saturated.
        if ((TIMEOUT_CYCLES != 0) && (stall_cnt_q != CNT_MAX) && (stall_cnt_d == CNT_MAX)) begin
            timeout_set = 1'b1;
        end

        if (i_timeout_clr) begin
            timeout_d = 1'b0;
        end
        if (timeout_set) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            data_q      <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            data_q      <= data_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_data    = data_q;
    assign o_req     = req_q;
    assign o_busy    = (state_q != IDLE);
    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_handshake_tx_ctrl.sv
// Directed bench for handshake_tx_ctrl: nominal, back-to-back, timeout, set/clear race, reset mid-transfer.
module tb_handshake_tx_ctrl;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_data;
    logic [31:0] o_data;
    logic        o_req;
    logic        i_ack;
    logic        o_busy;
    logic        o_timeout;
    logic        i_timeout_clr;

    int n_chk;
    int n_pass;

    handshake_tx_ctrl #(
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) u_dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_data        (i_data),
        .o_data        (o_data),
        .o_req         (o_req),
        .i_ack         (i_ack),
        .o_busy        (o_busy),
        .o_timeout     (o_timeout),
        .i_timeout_clr (i_timeout_clr)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        n_chk         = 0;
        n_pass        = 0;
        i_rst         = 1'b1;
        i_valid       = 1'b0;
        i_data        = '0;
        i_ack         = 1'b0;
        i_timeout_clr = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_req",     32'(o_req), 32'd0);
        chk("rst_data",    o_data, 32'h0);
        chk("rst_busy",    32'(o_busy), 32'd0);
        chk("rst_timeout", 32'(o_timeout), 32'd0);
        chk("rst_ready",   32'(o_ready), 32'd1);
        i_rst = 1'b0;
        tick();

        // Nominal transfer
        i_data  = 32'hDEADBEEF;
        i_valid = 1'b1;
        #1;
        chk("nom_ready_pre", 32'(o_ready), 32'd1);
        tick();
        i_valid = 1'b0;
        i_data  = 32'h0;
        chk("nom_req_rise", 32'(o_req), 32'd1);
        chk("nom_busy",     32'(o_busy), 32'd1);
        chk("nom_data",     o_data, 32'hDEADBEEF);
        chk("nom_ready_lo", 32'(o_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("nom_req_hold", 32'(o_req), 32'd1);
        end
        tick();
        i_ack = 1'b1;
        chk("nom_req_before_ack_edge", 32'(o_req), 32'd1);
        tick();
        chk("nom_req_drop", 32'(o_req), 32'd0);
        chk("nom_busy_wait", 32'(o_busy), 32'd1);
        chk("nom_data_wait", o_data, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("nom_ready_wait", 32'(o_ready), 32'd0);
        end
        tick();
        i_ack = 1'b0;
        #1;
        chk("nom_ready_ack_low_same", 32'(o_ready), 32'd0);
        tick();
        chk("nom_ready_back", 32'(o_ready), 32'd1);
        chk("nom_busy_idle",  32'(o_busy), 32'd0);
        chk("nom_data_idle",  o_data, 32'hDEADBEEF);
        chk("nom_no_timeout", 32'(o_timeout), 32'd0);

        // Back-to-back with i_valid held
        i_valid = 1'b1;
        i_data  = 32'h1;
        tick();
        i_data = 32'h2;
        chk("b2b_data1", o_data, 32'h1);
        chk("b2b_ready_lo", 32'(o_ready), 32'd0);
        tick();
        i_ack = 1'b1;
        chk("b2b_data1_req", o_data, 32'h1);
        tick();
        chk("b2b_data1_wait", o_data, 32'h1);
        chk("b2b_req_drop", 32'(o_req), 32'd0);
        i_ack = 1'b0;
        tick();
        chk("b2b_data1_idle", o_data, 32'h1);
        chk("b2b_ready_idle", 32'(o_ready), 32'd1);
        tick();
        chk("b2b_data2", o_data, 32'h2);
        chk("b2b_req2", 32'(o_req), 32'd1);
        i_valid = 1'b0;
        i_ack   = 1'b1;
        tick();
        i_ack = 1'b0;
        tick();
        chk("b2b_idle", 32'(o_busy), 32'd0);

        // Timeout with ack never rising
        i_valid = 1'b1;
        i_data  = 32'h33;
        tick();
        i_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("to_not_yet", 32'(o_timeout), 32'd0);
        end
        tick();
        chk("to_set", 32'(o_timeout), 32'd1);
        chk("to_req_kept", 32'(o_req), 32'd1);
        tick();
        tick();
        chk("to_sticky", 32'(o_timeout), 32'd1);
        i_timeout_clr = 1'b1;
        tick();
        i_timeout_clr = 1'b0;
        chk("to_cleared", 32'(o_timeout), 32'd0);
        chk("to_req_after_clr", 32'(o_req), 32'd1);
        chk("to_busy_after_clr", 32'(o_busy), 32'd1);
        tick();
        tick();
        chk("to_stays_clear", 32'(o_timeout), 32'd0);
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        tick();
        chk("to_idle", 32'(o_busy), 32'd0);

        // Set and clear in the same cycle
        i_valid = 1'b1;
        i_data  = 32'h44;
        tick();
        i_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        chk("race_pre", 32'(o_timeout), 32'd0);
        i_timeout_clr = 1'b1;
        tick();
        i_timeout_clr = 1'b0;
        chk("race_set_wins", 32'(o_timeout), 32'd1);

        // Reset in WAIT_ACK_LOW with ack still high
        i_ack = 1'b1;
        tick();
        chk("rmid_wait", 32'(o_busy), 32'd1);
        chk("rmid_data_pre", o_data, 32'h44);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("rmid_req",     32'(o_req), 32'd0);
        chk("rmid_data",    o_data, 32'h0);
        chk("rmid_busy",    32'(o_busy), 32'd0);
        chk("rmid_timeout", 32'(o_timeout), 32'd0);
        chk("rmid_ready",   32'(o_ready), 32'd0);
        i_valid = 1'b1;
        i_data  = 32'hA5;
        tick();
        chk("rmid_no_accept_busy", 32'(o_busy), 32'd0);
        chk("rmid_no_accept_data", o_data, 32'h0);
        i_ack = 1'b0;
        #1;
        chk("rmid_ready_ack_low", 32'(o_ready), 32'd1);
        tick();
        i_valid = 1'b0;
        chk("rmid_new_data", o_data, 32'hA5);
        chk("rmid_new_req",  32'(o_req), 32'd1);
        chk("rmid_new_busy", 32'(o_busy), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/handshake_tx_ctrl.md
HANDSHAKE_TX_CTRL -- requirements
Module: handshake_tx_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the width of the transferred word.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, the stall-cycle limit before the timeout flag is raised; 0 disables the timeout.
REQ-003 The block SHALL have port i_clk, input, 1, the sending-domain clock.
REQ-004 The block SHALL have port i_rst, input, 1, reset: one clock, reset is synchronous and active-high.
REQ-005 The block SHALL have port i_valid, input, 1, local word offered.
REQ-006 The block SHALL have port o_ready, output, 1, the block accepts a word this cycle.
REQ-007 The block SHALL have port i_data, input, DATA_WIDTH, local word.
REQ-008 The block SHALL have port o_data, output, DATA_WIDTH, the held word presented to the receiving domain.
REQ-009 The block SHALL have port o_req, output, 1, four-phase request, which feeds the handshake resync valid input.
REQ-010 The block SHALL have port i_ack, input, 1, acknowledge, already synchronised into i_clk by the handshake resync.
REQ-011 The block SHALL have port o_busy, output, 1, a transfer is in flight.
REQ-012 The block SHALL have port o_timeout, output, 1, sticky stall flag.
REQ-013 The block SHALL have port i_timeout_clr, input, 1, clears o_timeout.

Function
REQ-014 The block SHALL implement states IDLE, REQ and WAIT_ACK_LOW.
REQ-015 o_ready SHALL equal (state==IDLE) && !i_ack, combinationally; a stale high ack therefore blocks acceptance.
REQ-016 When i_valid && o_ready are high at a clock edge, the block SHALL register i_data into o_data, set o_req=1 and enter REQ, with o_req visible the cycle after the accept.
REQ-017 o_data SHALL change only on an accept, and SHALL stay stable from the accept until the block next returns to IDLE.
REQ-018 In REQ, when i_ack==1, the block SHALL clear o_req and enter WAIT_ACK_LOW on that edge.
REQ-019 In WAIT_ACK_LOW, when i_ack==0, the block SHALL enter IDLE, making o_ready high the following cycle.
REQ-020 o_busy SHALL be high in REQ and WAIT_ACK_LOW and low in IDLE.
REQ-021 The minimum cycle count from accept to the next possible accept SHALL be 3 plus the round-trip synchroniser latency; no back-to-back accepts SHALL occur.
REQ-022 The stall counter SHALL clear on every state transition and on entry to IDLE.
REQ-023 In REQ or WAIT_ACK_LOW, the stall counter SHALL increment each cycle and saturate at TIMEOUT_CYCLES.
REQ-024 The stall counter width SHALL be $clog2(TIMEOUT_CYCLES+1), with a minimum of 1.
REQ-025 When the stall counter equals TIMEOUT_CYCLES and TIMEOUT_CYCLES!=0, o_timeout SHALL set to 1 and remain set.
REQ-026 A timeout SHALL NOT abort the handshake: o_req and state SHALL be unaffected.
REQ-027 i_timeout_clr SHALL clear o_timeout; if clear and set occur in the same cycle, set SHALL win.
REQ-028 i_valid deasserting while o_ready is low SHALL have no effect; the block SHALL not require i_valid to be held.

Reset
REQ-029 While i_rst is high, the block SHALL force state=IDLE, o_req=0, o_data=0, o_timeout=0 and stall counter=0; o_busy=0 follows from IDLE.
REQ-030 Reset during REQ or WAIT_ACK_LOW SHALL drop o_req immediately on that edge, and the in-flight word SHALL be discarded.
REQ-031 After reset, no word SHALL be accepted until i_ack is observed low, per REQ-015.

Structure
REQ-032 The state typedef (tx_state_t: IDLE, REQ, WAIT_ACK_LOW) SHALL live in the shared resync package; no other constants SHALL be shared.
REQ-033 The block SHALL contain no sub-modules; the handshake resync SHALL be instantiated beside it at the integration level, not inside it.
REQ-034 The block SHALL contain no synchronisers of its own; i_ack SHALL be treated as synchronous.

Verification
REQ-035 Nominal transfer: i_data=0xDEADBEEF, i_valid pulsed 1 cycle, ack rising 4 cycles after o_req and falling 4 cycles after o_req drops -> o_data=0xDEADBEEF held throughout; o_req high exactly until the ack-high edge; o_ready back to 1 one cycle after ack low.
REQ-036 Back-to-back: i_valid held high with words 0x1 then 0x2 -> second accept only after return to IDLE; o_data changes 0x1->0x2 exactly at the second accept.
REQ-037 Timeout: TIMEOUT_CYCLES=8, ack never rises -> o_timeout=1 on the 8th stall cycle; o_req stays 1; i_timeout_clr pulse -> o_timeout=0 while o_req stays 1.
REQ-038 Simultaneous set and clear: TIMEOUT_CYCLES=8, i_timeout_clr asserted on the set cycle -> o_timeout=1.
REQ-039 Reset mid-operation: i_rst asserted in WAIT_ACK_LOW with i_ack=1 -> o_req=0 and o_data=0 next cycle; o_ready stays 0 until i_ack=0, then a new word 0xA5 is accepted normally.
